// File: rtl/router_pair_scheduler_if.sv
// Router-side handshake bundle shared by the input router and the weight router.
// The scheduler drives enables/clears/pops and the channel index; the routers return ready and context-done.
interface router_pair_scheduler_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] o_i_c;
  logic                  o_ir_en;
  logic                  o_ir_reg_clear;
  logic                  o_ir_pop_en;
  logic                  i_ir_ready;
  logic                  i_ir_context_done;
  logic                  o_wr_en;
  logic                  o_wr_reg_clear;
  logic                  o_wr_pop_en;
  logic                  i_wr_ready;
  logic                  i_wr_context_done;

  modport master (
    output o_i_c,
    output o_ir_en, o_ir_reg_clear, o_ir_pop_en,
    input  i_ir_ready, i_ir_context_done,
    output o_wr_en, o_wr_reg_clear, o_wr_pop_en,
    input  i_wr_ready, i_wr_context_done
  );

  modport slave (
    input  o_i_c,
    input  o_ir_en, o_ir_reg_clear, o_ir_pop_en,
    output i_ir_ready, i_ir_context_done,
    input  o_wr_en, o_wr_reg_clear, o_wr_pop_en,
    output i_wr_ready, i_wr_context_done
  );
endinterface

// File: rtl/router_pair_scheduler.sv
// Walks the input-channel loop of a layer: clear, load and stream both routers in lockstep per channel.
// Pops follow i_acc_ready with zero latency; abort clears both routers for one cycle and returns to IDLE.
module router_pair_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [ADDR_WIDTH-1:0]   i_c_size,
  input  logic                    i_acc_ready,
  router_pair_scheduler_if.master rt_if,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [CNT_WIDTH-1:0]    o_pop_cnt,
  output logic [CNT_WIDTH-1:0]    o_stall_cnt,
  output logic [2:0]              o_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ABORT  = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] c_size_q, c_size_d;
  logic [ADDR_WIDTH-1:0] i_c_q, i_c_d;
  logic [CNT_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  rdy_ir_q, rdy_ir_d, rdy_wr_q, rdy_wr_d;
  logic                  cd_ir_q, cd_ir_d, cd_wr_q, cd_wr_d;
  logic                  en, clr, pop;

  always_comb begin
    state_d     = state_q;
    c_size_d    = c_size_q;
    i_c_d       = i_c_q;
    pop_cnt_d   = pop_cnt_q;
    stall_cnt_d = stall_cnt_q;
    rdy_ir_d    = rdy_ir_q;
    rdy_wr_d    = rdy_wr_q;
    cd_ir_d     = cd_ir_q;
    cd_wr_d     = cd_wr_q;
    en          = 1'b0;
    clr         = 1'b0;
    pop         = 1'b0;
    o_done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          c_size_d    = i_c_size;
          i_c_d       = '0;
          pop_cnt_d   = '0;
          stall_cnt_d = '0;
          state_d     = (i_c_size == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR, ST_ABORT: begin
        clr      = 1'b1;
        rdy_ir_d = 1'b0;
        rdy_wr_d = 1'b0;
        cd_ir_d  = 1'b0;
        cd_wr_d  = 1'b0;
        state_d  = (state_q == ST_CLEAR) ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        en = 1'b1;
        if (rt_if.i_ir_ready)        rdy_ir_d = 1'b1;
        if (rt_if.i_wr_ready)        rdy_wr_d = 1'b1;
        // Context-done can legally arrive before streaming starts.
        if (rt_if.i_ir_context_done) cd_ir_d = 1'b1;
        if (rt_if.i_wr_context_done) cd_wr_d = 1'b1;
        if ((rdy_ir_q | rt_if.i_ir_ready) & (rdy_wr_q | rt_if.i_wr_ready))
          state_d = ST_STREAM;
      end
      ST_STREAM: begin
        en  = 1'b1;
        pop = i_acc_ready;
        if (i_acc_ready) begin
          if (pop_cnt_q != '1)   pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (rt_if.i_ir_context_done) cd_ir_d = 1'b1;
        if (rt_if.i_wr_context_done) cd_wr_d = 1'b1;
        if ((cd_ir_q | rt_if.i_ir_context_done) & (cd_wr_q | rt_if.i_wr_context_done))
          state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (i_c_q == c_size_q - ADDR_WIDTH'(1)) begin
          state_d = ST_DONE;
        end else begin
          i_c_d   = i_c_q + ADDR_WIDTH'(1);
          state_d = ST_CLEAR;
        end
      end
      ST_DONE: begin
        o_done  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides any transition; the channel index must not advance under it.
    if (i_abort && state_q != ST_IDLE && state_q != ST_ABORT) begin
      state_d = ST_ABORT;
      i_c_d   = i_c_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      c_size_q    <= '0;
      i_c_q       <= '0;
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
      rdy_ir_q    <= 1'b0;
      rdy_wr_q    <= 1'b0;
      cd_ir_q     <= 1'b0;
      cd_wr_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_size_q    <= c_size_d;
      i_c_q       <= i_c_d;
      pop_cnt_q   <= pop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      rdy_ir_q    <= rdy_ir_d;
      rdy_wr_q    <= rdy_wr_d;
      cd_ir_q     <= cd_ir_d;
      cd_wr_q     <= cd_wr_d;
    end
  end

  assign rt_if.o_i_c          = i_c_q;
  assign rt_if.o_ir_en        = en;
  assign rt_if.o_wr_en        = en;
  assign rt_if.o_ir_reg_clear = clr;
  assign rt_if.o_wr_reg_clear = clr;
  assign rt_if.o_ir_pop_en    = pop;
  assign rt_if.o_wr_pop_en    = pop;

  assign o_busy      = (state_q != ST_IDLE);
  assign o_pop_cnt   = pop_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
  // The abort cycle reports as CLEAR since its outputs are identical.
  assign o_state     = (state_q == ST_ABORT) ? 3'd1 : 3'(state_q);

endmodule
